// File: rtl/loader_wr_fifo.sv
// Small FIFO between GameLoader byte writes and the SDRAM write port.
// Each queued write is replayed on a NES CE slot and held for one full slot period.
module loader_wr_fifo #(
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  slot,
    input  logic                  in_write,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [7:0]            in_data,
    output logic                  out_write,
    output logic [ADDR_W-1:0]     out_addr,
    output logic [7:0]            out_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [ADDR_W-1:0]     wr_count
);

    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned EW    = ADDR_W + 8;

    logic [EW-1:0]       mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       level_q, level_d;
    logic                out_write_q, out_write_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                overflow_q, overflow_d;
    logic [ADDR_W-1:0]   wr_count_q, wr_count_d;
    logic                enable_q, enable_d;

    logic                empty, full, pop, push;
    logic [EW-1:0]       head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign head  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    // Pop sees only entries present before this edge, so a slot-cycle push is not bypassed.
    assign pop  = enable && slot && !empty;
    assign push = enable && in_write && (!full || pop);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        out_write_d = out_write_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        overflow_d  = overflow_q;
        wr_count_d  = wr_count_q;
        enable_d    = enable;
        if (!enable) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            out_write_d = 1'b0;
        end else begin
            if (!enable_q) begin
                overflow_d = 1'b0;
                wr_count_d = '0;
            end
            if (slot) begin
                out_write_d = !empty;
            end
            if (pop) begin
                out_addr_d = head[EW-1:8];
                out_data_d = head[7:0];
                rd_ptr_d   = rd_ptr_q + PW'(1);
                wr_count_d = wr_count_d + ADDR_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (in_write && !push) begin
                overflow_d = 1'b1;
            end
            level_d = level_q + PW'(push) - PW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_write_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
            wr_count_q  <= '0;
            enable_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_write_q <= out_write_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
            wr_count_q  <= wr_count_d;
            enable_q    <= enable_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {in_addr, in_data};
        end
    end

    assign out_write = out_write_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_loader_wr_fifo.sv
// Scoreboard bench for loader_wr_fifo: a queue-based model predicts every cycle,
// a monitor compares outputs one cycle later and checks issued writes in order.
module tb_loader_wr_fifo;

    localparam int unsigned AW    = 12;
    localparam int unsigned DL2   = 2;
    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic            slot = 1'b0;
    logic            in_write = 1'b0;
    logic [AW-1:0]   in_addr = '0;
    logic [7:0]      in_data = '0;
    logic            out_write;
    logic [AW-1:0]   out_addr;
    logic [7:0]      out_data;
    logic [DL2:0]    level;
    logic            overflow;
    logic [AW-1:0]   wr_count;

    loader_wr_fifo #(.ADDR_W(AW), .DEPTH_LOG2(DL2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .slot(slot),
        .in_write(in_write), .in_addr(in_addr), .in_data(in_data),
        .out_write(out_write), .out_addr(out_addr), .out_data(out_data),
        .level(level), .overflow(overflow), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ow;
        int            lvl;
        logic          ovf;
        logic [AW-1:0] cnt;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          nw;
    } st_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } ent_t;

    st_t  exp_st_q [$];
    ent_t exp_wr_q [$];
    ent_t mq [$];

    logic          m_ow = 1'b0, m_ovf = 1'b0, m_enp = 1'b0;
    logic [AW-1:0] m_cnt = '0, m_addr = '0;
    logic [7:0]    m_data = '0;
    int            ph = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    bit            drv_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference behaviour for the edge that follows the inputs just driven.
    task automatic model(input logic r, input logic e, input logic s, input logic w,
                         input logic [AW-1:0] a, input logic [7:0] d);
        st_t  st;
        ent_t ent;
        st.nw = 1'b0;
        if (r) begin
            mq.delete();
            m_ow = 0; m_addr = '0; m_data = '0; m_ovf = 0; m_cnt = '0; m_enp = 0;
        end else if (!e) begin
            mq.delete();
            m_ow = 0; m_enp = 0;
        end else begin
            if (!m_enp) begin
                m_ovf = 0; m_cnt = '0;
            end
            if (s) begin
                if (mq.size() > 0) begin
                    ent = mq.pop_front();
                    m_ow = 1; m_addr = ent.addr; m_data = ent.data;
                    m_cnt = m_cnt + 1'b1;
                    exp_wr_q.push_back(ent);
                    st.nw = 1'b1;
                end else begin
                    m_ow = 0;
                end
            end
            if (w) begin
                if (mq.size() < DEPTH) begin
                    ent.addr = a; ent.data = d;
                    mq.push_back(ent);
                end else begin
                    m_ovf = 1;
                end
            end
            m_enp = 1;
        end
        st.ow = m_ow; st.lvl = mq.size(); st.ovf = m_ovf; st.cnt = m_cnt;
        st.addr = m_addr; st.data = m_data;
        exp_st_q.push_back(st);
    endtask

    task automatic cyc(input logic r, input logic e, input logic w,
                       input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        reset = r; enable = e; in_write = w; in_addr = a; in_data = d;
        slot = (ph == 3);
        model(r, e, slot, w, a, d);
        ph = (ph + 1) % 4;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, '0, '0);
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 4 && ph != p; i++) cyc(0, 1, 0, '0, '0);
    endtask

    initial begin : monitor
        st_t  st;
        ent_t ent;
        forever begin
            @(posedge clk);
            #1;
            if (exp_st_q.size() > 0) begin
                st = exp_st_q.pop_front();
                chk("out_write", 32'(out_write), 32'(st.ow));
                chk("level",     32'(level),     32'(st.lvl));
                chk("overflow",  32'(overflow),  32'(st.ovf));
                chk("wr_count",  32'(wr_count),  32'(st.cnt));
                chk("out_addr",  32'(out_addr),  32'(st.addr));
                chk("out_data",  32'(out_data),  32'(st.data));
                if (st.nw) begin
                    if (exp_wr_q.size() == 0) begin
                        chk("wr_queue_underrun", 32'(1), 32'(0));
                    end else begin
                        ent = exp_wr_q.pop_front();
                        chk("sb_addr", 32'(out_addr), 32'(ent.addr));
                        chk("sb_data", 32'(out_data), 32'(ent.data));
                    end
                end
            end
        end
    end

    initial begin : driver
        logic [AW-1:0] sa;
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, AW'($urandom), 8'($urandom));

        wait_phase(1);
        cyc(0, 1, 1, AW'(12'h010), 8'hA5);
        idle(10);

        wait_phase(3);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, AW'(12'h020 + i), 8'(8'h30 + i));
        idle(20);

        wait_phase(3);
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, AW'(12'h080 + i), 8'(8'h90 + i));
        idle(24);

        wait_phase(3);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, AW'(12'h100 + i), 8'(8'hC0 + i));
        cyc(0, 1, 0, '0, '0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, AW'(12'h200 + i), 8'h77);
        idle(12);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 49) != 0),
                ($urandom_range(0, 9) < 4), AW'($urandom), 8'($urandom));
        end

        cyc(0, 0, 0, '0, '0);
        cyc(0, 0, 0, '0, '0);
        sa = '0;
        wait_phase(1);
        for (int i = 0; i < 4200; i++) begin
            cyc(0, 1, 1, sa, sa[7:0] ^ 8'h5A);
            sa = sa + 1'b1;
            cyc(0, 1, 0, '0, '0);
            cyc(0, 1, 0, '0, '0);
            cyc(0, 1, 0, '0, '0);
        end
        idle(12);

        @(posedge clk);
        #2;
        chk("pending_writes", 32'(exp_wr_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
